// File: rtl/combo_lock_pkg.sv
// Shared state encodings and display codes for the combination lock controller.
package combo_lock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED  = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_PROGRAM = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  localparam logic [3:0] DISP_OPEN    = 4'hA;
  localparam logic [3:0] DISP_LOCKOUT = 4'hE;

endpackage

// File: rtl/combo_lock_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button level; history resets to 1 so a
// button held through reset never produces a spurious edge.
module btn_edge (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_level,
  output logic o_edge
);

  logic r_prev;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_prev <= 1'b1;
    else         r_prev <= i_level;
  end

  assign o_edge = i_level & ~r_prev;

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination lock sequencer: digit entry, code compare, reprogramming while
// open, auto-relock and timed lockout after repeated failures.
//
// state   | meaning
// LOCKED  | idle, waiting for first digit
// ENTRY   | collecting code digits
// CHECK   | one-cycle compare of entry against stored code
// OPEN    | unlocked, relock timer running
// PROGRAM | collecting a new code into staging, timer frozen
// LOCKOUT | alarm, all buttons ignored until timer expires
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int unsigned           CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned           MAX_FAIL       = 3,
  parameter int unsigned           LOCKOUT_CYCLES = 300_000_000,
  parameter int unsigned           UNLOCK_CYCLES  = 1_000_000_000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [3:0] i_digit,
  input  logic       i_enter,
  input  logic       i_set_code,
  input  logic       i_lock,
  output logic       o_unlocked,
  output logic       o_alarm,
  output logic [2:0] o_entry_count,
  output logic [1:0] o_fail_count,
  output logic [3:0] o_disp_val,
  output logic [2:0] o_state
);

  localparam int CW = 4 * CODE_LEN;
  localparam logic [31:0] UNLOCK_LOAD  = 32'(UNLOCK_CYCLES - 1);
  localparam logic [31:0] LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 1);

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_entry, r_stage, r_code;
  logic [2:0]      r_entry_count;
  logic [1:0]      r_fail_count;
  logic [3:0]      r_last_digit;
  logic [31:0]     r_timer;

  logic w_enter_edge, w_set_edge, w_lock_edge;
  logic w_act_lock, w_act_set, w_act_enter;
  logic [2:0]    w_count_next;
  logic          w_last_digit;
  logic [1:0]    w_fail_next;
  logic          w_fail_max;
  logic          w_match;
  logic          w_tmr_zero;
  logic [CW-1:0] w_entry_shift, w_stage_shift;

  btn_edge u_edge_enter (.i_clock(i_clock), .i_reset(i_reset), .i_level(i_enter),    .o_edge(w_enter_edge));
  btn_edge u_edge_set   (.i_clock(i_clock), .i_reset(i_reset), .i_level(i_set_code), .o_edge(w_set_edge));
  btn_edge u_edge_lock  (.i_clock(i_clock), .i_reset(i_reset), .i_level(i_lock),     .o_edge(w_lock_edge));

  // One action per cycle: lock beats set_code beats enter.
  assign w_act_lock  = w_lock_edge;
  assign w_act_set   = w_set_edge & ~w_lock_edge;
  assign w_act_enter = w_enter_edge & ~w_set_edge & ~w_lock_edge;

  assign w_count_next  = r_entry_count + 3'd1;
  assign w_last_digit  = (w_count_next == 3'(CODE_LEN));
  assign w_fail_next   = r_fail_count + 2'd1;
  assign w_fail_max    = (w_fail_next == 2'(MAX_FAIL));
  assign w_match       = (r_entry == r_code);
  assign w_tmr_zero    = (r_timer == 32'd0);
  assign w_entry_shift = {r_entry[CW-5:0], i_digit};
  assign w_stage_shift = {r_stage[CW-5:0], i_digit};

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_LOCKED;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOCKED:  if (w_act_enter) w_state_next = w_last_digit ? ST_CHECK : ST_ENTRY;
      ST_ENTRY: begin
        if (w_act_lock)                        w_state_next = ST_LOCKED;
        else if (w_act_enter && w_last_digit)  w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_match)         w_state_next = ST_OPEN;
        else if (w_fail_max) w_state_next = ST_LOCKOUT;
        else                 w_state_next = ST_LOCKED;
      end
      ST_OPEN: begin
        if (w_act_lock || w_tmr_zero) w_state_next = ST_LOCKED;
        else if (w_act_set)           w_state_next = ST_PROGRAM;
      end
      ST_PROGRAM: begin
        if (w_act_lock || (w_act_enter && w_last_digit)) w_state_next = ST_OPEN;
      end
      ST_LOCKOUT: if (w_tmr_zero) w_state_next = ST_LOCKED;
      default:    w_state_next = ST_LOCKED;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_entry       <= '0;
      r_stage       <= '0;
      r_code        <= DEFAULT_CODE;
      r_entry_count <= 3'd0;
      r_fail_count  <= 2'd0;
      r_last_digit  <= 4'd0;
      r_timer       <= 32'd0;
    end else begin
      case (r_state)
        ST_LOCKED, ST_ENTRY: begin
          if (r_state == ST_ENTRY && w_act_lock) begin
            r_entry       <= '0;
            r_entry_count <= 3'd0;
          end else if (w_act_enter) begin
            r_entry       <= w_entry_shift;
            r_entry_count <= w_count_next;
            r_last_digit  <= i_digit;
          end
        end
        ST_CHECK: begin
          r_entry       <= '0;
          r_entry_count <= 3'd0;
          if (w_match) begin
            r_fail_count <= 2'd0;
            r_timer      <= UNLOCK_LOAD;
          end else begin
            r_fail_count <= w_fail_next;
            if (w_fail_max) r_timer <= LOCKOUT_LOAD;
          end
        end
        ST_OPEN: begin
          if (w_act_lock || w_tmr_zero) begin
            r_timer <= 32'd0;
          end else if (w_act_set) begin
            r_stage       <= '0;
            r_entry_count <= 3'd0;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        ST_PROGRAM: begin
          if (w_act_lock) begin
            r_timer       <= UNLOCK_LOAD;
            r_entry_count <= 3'd0;
          end else if (w_act_enter) begin
            r_stage      <= w_stage_shift;
            r_last_digit <= i_digit;
            if (w_last_digit) begin
              r_code        <= w_stage_shift;
              r_timer       <= UNLOCK_LOAD;
              r_entry_count <= 3'd0;
            end else begin
              r_entry_count <= w_count_next;
            end
          end
        end
        ST_LOCKOUT: begin
          if (w_tmr_zero) r_fail_count <= 2'd0;
          else            r_timer      <= r_timer - 32'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_unlocked = 1'b0;
    o_alarm    = 1'b0;
    o_disp_val = r_last_digit;
    case (r_state)
      ST_OPEN: begin
        o_unlocked = 1'b1;
        o_disp_val = DISP_OPEN;
      end
      ST_LOCKOUT: begin
        o_alarm    = 1'b1;
        o_disp_val = DISP_LOCKOUT;
      end
      default: ;
    endcase
  end

  assign o_entry_count = r_entry_count;
  assign o_fail_count  = r_fail_count;
  assign o_state       = r_state;

endmodule
